// File: rtl/cpu_bus_responder.sv
// Bus-side responder for the 6502 core: on-chip RAM, fixed vectors, a free-running
// timer with a coherent hi-byte shadow, and a FIFO-backed byte output port.
module cpu_bus_responder #(
    parameter int          RAM_AW     = 11,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] NMI_VEC    = 16'h0000,
    parameter logic [15:0] RST_VEC    = 16'h0200,
    parameter logic [15:0] IRQ_VEC    = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] address,
    input  logic        read_write,
    input  logic [7:0]  data_write,
    output logic [7:0]  data_read,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int RAM_WORDS = 2 ** RAM_AW;

    localparam logic [15:0] ADDR_OUT_DATA = 16'hFE00;
    localparam logic [15:0] ADDR_STATUS   = 16'hFE01;
    localparam logic [15:0] ADDR_TIMER_LO = 16'hFE02;
    localparam logic [15:0] ADDR_TIMER_HI = 16'hFE03;

    logic [7:0]    ram [RAM_WORDS];
    logic [7:0]    fifo_mem [FIFO_DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic [7:0]    last_byte;
    logic [15:0]   timer;
    logic [7:0]    hi_shadow;

    logic          is_write;
    logic          ram_hit;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push_req;
    logic          push_ok;
    logic          pop;
    logic          status_write;
    logic          timer_lo_read;
    logic [3:0]    count_ext;
    logic [7:0]    status;

    assign is_write      = ~read_write;
    assign ram_hit       = (address >> RAM_AW) == 16'd0;
    assign fifo_full     = (count == CW'(FIFO_DEPTH));
    assign fifo_empty    = (count == '0);
    assign out_valid     = ~fifo_empty;
    assign pop           = out_valid & out_ready;
    assign push_req      = is_write & (address == ADDR_OUT_DATA);
    // A push into a full FIFO still lands when the head leaves on the same edge.
    assign push_ok       = push_req & (~fifo_full | pop);
    assign status_write  = is_write & (address == ADDR_STATUS);
    assign timer_lo_read = read_write & (address == ADDR_TIMER_LO);
    assign count_ext     = 4'(count);
    assign status        = {1'b0, count_ext, overflow, fifo_empty, fifo_full};

    // Outside of valid the head slot holds stale data, so it is masked to zero.
    assign out_data = out_valid ? fifo_mem[rd_ptr] : 8'h00;

    always_comb begin
        data_read = 8'hFF;
        if (ram_hit) begin
            data_read = ram[address[RAM_AW-1:0]];
        end else begin
            case (address)
                ADDR_OUT_DATA: data_read = last_byte;
                ADDR_STATUS:   data_read = status;
                ADDR_TIMER_LO: data_read = timer[7:0];
                ADDR_TIMER_HI: data_read = hi_shadow;
                16'hFFFA:      data_read = NMI_VEC[7:0];
                16'hFFFB:      data_read = NMI_VEC[15:8];
                16'hFFFC:      data_read = RST_VEC[7:0];
                16'hFFFD:      data_read = RST_VEC[15:8];
                16'hFFFE:      data_read = IRQ_VEC[7:0];
                16'hFFFF:      data_read = IRQ_VEC[15:8];
                default:       data_read = 8'hFF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && is_write && ram_hit) begin
            ram[address[RAM_AW-1:0]] <= data_write;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            fifo_mem[wr_ptr] <= data_write;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            last_byte <= 8'h00;
        end else begin
            if (push_ok) begin
                wr_ptr    <= wr_ptr + 1'b1;
                last_byte <= data_write;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (status_write) begin
                overflow <= 1'b0;
            end else if (push_req && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

    // The hi byte is captured on a LO read so software sees a coherent 16-bit value.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer     <= 16'h0000;
            hi_shadow <= 8'h00;
        end else begin
            timer <= timer + 16'd1;
            if (timer_lo_read) begin
                hi_shadow <= timer[15:8];
            end
        end
    end

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Directed self-checking bench for cpu_bus_responder: memory map, FIFO, timer and reset.
module tb_cpu_bus_responder;

    logic        clk;
    logic        rst;
    logic [15:0] address;
    logic        read_write;
    logic [7:0]  data_write;
    logic [7:0]  data_read;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;

    int errors;
    int checks;
    int model_timer;

    cpu_bus_responder dut (
        .clk        (clk),
        .rst        (rst),
        .address    (address),
        .read_write (read_write),
        .data_write (data_write),
        .data_read  (data_read),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs change and outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
        model_timer = (model_timer + 1) & 16'hFFFF;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_timer = 0;
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] d);
        address    = a;
        data_write = d;
        read_write = 1'b0;
        tick();
        read_write = 1'b1;
        address    = 16'h9000;
    endtask

    task automatic test_reset();
        out_ready = 1'b0;
        do_reset();
        address = 16'hFFFC; #1;
        checks++; if (data_read !== 8'h00) begin errors++; $display("[TB] FAIL rst_vec_lo: got %h want 00", data_read); end
        address = 16'hFFFD; #1;
        checks++; if (data_read !== 8'h02) begin errors++; $display("[TB] FAIL rst_vec_hi: got %h want 02", data_read); end
        address = 16'hFE01; #1;
        checks++; if (data_read !== 8'h02) begin errors++; $display("[TB] FAIL reset_status: got %h want 02", data_read); end
        address = 16'h9000; #1;
        checks++; if (data_read !== 8'hFF) begin errors++; $display("[TB] FAIL unmapped: got %h want ff", data_read); end
        checks++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_out: got v=%b d=%h want v=0 d=00", out_valid, out_data); end
        address = 16'hFE03; #1;
        checks++; if (data_read !== 8'h00) begin errors++; $display("[TB] FAIL reset_hi_shadow: got %h want 00", data_read); end
        address = 16'h9000;
    endtask

    task automatic test_ram_and_vectors();
        do_write(16'h0123, 8'h5A);
        do_write(16'h07FF, 8'hC3);
        address = 16'h0123; #1;
        checks++; if (data_read !== 8'h5A) begin errors++; $display("[TB] FAIL ram_0123: got %h want 5a", data_read); end
        address = 16'h07FF; #1;
        checks++; if (data_read !== 8'hC3) begin errors++; $display("[TB] FAIL ram_top: got %h want c3", data_read); end
        do_write(16'hFFFC, 8'h77);
        address = 16'hFFFC; #1;
        checks++; if (data_read !== 8'h00) begin errors++; $display("[TB] FAIL vec_write_ignored: got %h want 00", data_read); end
        address = 16'hFFFA; #1;
        checks++; if (data_read !== 8'h00) begin errors++; $display("[TB] FAIL nmi_vec_lo: got %h want 00", data_read); end
        address = 16'h0800; #1;
        checks++; if (data_read !== 8'hFF) begin errors++; $display("[TB] FAIL above_ram: got %h want ff", data_read); end
        address = 16'h9000;
    endtask

    task automatic test_fifo_fill_overflow();
        logic [7:0] pushes [4];
        pushes[0] = 8'h11; pushes[1] = 8'h22; pushes[2] = 8'h33; pushes[3] = 8'h44;
        out_ready = 1'b0;
        do_write(16'hFE00, pushes[0]);
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h11) begin errors++; $display("[TB] FAIL first_push: got v=%b d=%h want v=1 d=11", out_valid, out_data); end
        do_write(16'hFE00, pushes[1]);
        address = 16'hFE01; #1;
        checks++; if (data_read !== 8'h10) begin errors++; $display("[TB] FAIL status_two: got %h want 10", data_read); end
        for (int i = 2; i < 4; i++) do_write(16'hFE00, pushes[i]);
        address = 16'hFE01; #1;
        checks++; if (data_read !== 8'h21) begin errors++; $display("[TB] FAIL status_full: got %h want 21", data_read); end
        do_write(16'hFE00, 8'h55);
        address = 16'hFE01; #1;
        checks++; if (data_read !== 8'h25) begin errors++; $display("[TB] FAIL status_overflow: got %h want 25", data_read); end
        address = 16'hFE00; #1;
        checks++; if (data_read !== 8'h44) begin errors++; $display("[TB] FAIL last_byte_kept: got %h want 44", data_read); end
        checks++; if (out_data !== 8'h11) begin errors++; $display("[TB] FAIL head_stable: got %h want 11", out_data); end
        do_write(16'hFE01, 8'h00);
        address = 16'hFE01; #1;
        checks++; if (data_read !== 8'h21) begin errors++; $display("[TB] FAIL overflow_clear: got %h want 21", data_read); end
        address = 16'h9000;
    endtask

    task automatic test_full_push_pop_and_drain();
        logic [7:0] drain [4];
        drain[0] = 8'h22; drain[1] = 8'h33; drain[2] = 8'h44; drain[3] = 8'h66;
        out_ready = 1'b1;
        do_write(16'hFE00, 8'h66);
        out_ready = 1'b0;
        address = 16'hFE01; #1;
        checks++; if (data_read !== 8'h21) begin errors++; $display("[TB] FAIL full_swap_status: got %h want 21", data_read); end
        address = 16'hFE00; #1;
        checks++; if (data_read !== 8'h66) begin errors++; $display("[TB] FAIL full_swap_last: got %h want 66", data_read); end
        address = 16'h9000;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (out_valid !== 1'b1 || out_data !== drain[i]) begin errors++; $display("[TB] FAIL drain_%0d: got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, drain[i]); end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        address = 16'hFE01; #1;
        checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || data_read !== 8'h02) begin errors++; $display("[TB] FAIL drained: got v=%b d=%h st=%h want v=0 d=00 st=02", out_valid, out_data, data_read); end
        address = 16'h9000;
    endtask

    task automatic test_empty_push_with_ready();
        out_ready = 1'b1;
        do_write(16'hFE00, 8'h9C);
        out_ready = 1'b0;
        address = 16'hFE01; #1;
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h9C || data_read !== 8'h08) begin errors++; $display("[TB] FAIL empty_push: got v=%b d=%h st=%h want v=1 d=9c st=08", out_valid, out_data, data_read); end
        address = 16'h9000;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL empty_push_pop: got v=%b want v=0", out_valid); end
    endtask

    task automatic test_timer();
        do_reset();
        address = 16'h9000;
        while (model_timer != 16'h01FF) tick();
        address = 16'hFE02; #1;
        checks++; if (data_read !== 8'hFF) begin errors++; $display("[TB] FAIL timer_lo_01ff: got %h want ff", data_read); end
        tick();
        address = 16'hFE03; #1;
        checks++; if (data_read !== 8'h01) begin errors++; $display("[TB] FAIL timer_hi_coherent: got %h want 01", data_read); end
        address = 16'h9000;
        while (model_timer != 16'hFFFF) tick();
        address = 16'hFE02; #1;
        checks++; if (data_read !== 8'hFF) begin errors++; $display("[TB] FAIL timer_lo_ffff: got %h want ff", data_read); end
        tick();
        checks++; if (data_read !== 8'h00) begin errors++; $display("[TB] FAIL timer_wrap_lo: got %h want 00", data_read); end
        address = 16'hFE03; #1;
        checks++; if (data_read !== 8'hFF) begin errors++; $display("[TB] FAIL timer_hi_ffff: got %h want ff", data_read); end
        address = 16'hFE02;
        tick();
        address = 16'hFE03; #1;
        checks++; if (data_read !== 8'h00) begin errors++; $display("[TB] FAIL timer_wrap_hi: got %h want 00", data_read); end
        address = 16'h9000;
    endtask

    task automatic test_reset_mid_drain();
        out_ready = 1'b0;
        do_write(16'hFE00, 8'hAA);
        do_write(16'hFE00, 8'hBB);
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'hBB) begin errors++; $display("[TB] FAIL mid_drain: got v=%b d=%h want v=1 d=bb", out_valid, out_data); end
        address    = 16'hFE00;
        data_write = 8'hCC;
        read_write = 1'b0;
        do_reset();
        read_write = 1'b1;
        out_ready  = 1'b0;
        address = 16'hFE01; #1;
        checks++; if (out_valid !== 1'b0 || data_read !== 8'h02) begin errors++; $display("[TB] FAIL reset_drain: got v=%b st=%h want v=0 st=02", out_valid, data_read); end
        address = 16'hFE02; #1;
        checks++; if (data_read !== 8'h00) begin errors++; $display("[TB] FAIL reset_timer: got %h want 00", data_read); end
        address = 16'hFE00; #1;
        checks++; if (data_read !== 8'h00) begin errors++; $display("[TB] FAIL reset_last_byte: got %h want 00", data_read); end
        address = 16'h9000;
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        model_timer = 0;
        rst         = 1'b1;
        address     = 16'h9000;
        read_write  = 1'b1;
        data_write  = 8'h00;
        out_ready   = 1'b0;
        #2;
        test_reset();
        test_ram_and_vectors();
        test_fifo_fill_overflow();
        test_full_push_pop_and_drain();
        test_empty_push_with_ready();
        test_timer();
        test_reset_mid_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
